// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen
// ----------------------------------------------------------------------------
// Purpose:
//   Generates the VGA raster timing. It provides the horizontal and vertical
//   pixel counters, the active-low sync pulses, the active-video flag and the
//   line/frame start strobes. An internal clock-enable divider derives the
//   pixel rate from iClk, so the whole block runs in one clock domain.
//
// Ports:
//   iClk        in   1             system clock
//   iRst        in   1             synchronous active-high reset
//   oCountH     out  clog2(H_TOT)  horizontal pixel count, 0..H_TOT-1
//   oCountV     out  clog2(V_TOT)  vertical line count, 0..V_TOT-1
//   oPixTick    out  1             one-iClk pulse on each pixel advance
//   oHS         out  1             horizontal sync, active low
//   oVS         out  1             vertical sync, active low
//   oActive     out  1             high inside the visible window
//   oLineStart  out  1             one-iClk pulse when oCountH wraps to 0
//   oFrameStart out  1             one-iClk pulse when both counters wrap to 0
//   oFrameCnt   out  16            frame counter (only with VGA_FRAME_CNT_EN)
//
// Optional build macro:
//   VGA_FRAME_CNT_EN - adds oFrameCnt, a 16-bit wrapping count of frame
//                      starts. Without it the port and counter are absent.
//
// Timing:
//   Every output is a register. The flags are computed from the next count
//   values, so each flag is valid in the same cycle as the count it
//   describes.
// ============================================================================
module vga_timing_gen #(
    parameter int H_TOT   = 800,
    parameter int V_TOT   = 525,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    output logic [$clog2(H_TOT)-1:0] oCountH,
    output logic [$clog2(V_TOT)-1:0] oCountV,
    output logic                     oPixTick,
    output logic                     oHS,
    output logic                     oVS,
    output logic                     oActive,
    output logic                     oLineStart,
    output logic                     oFrameStart
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]              oFrameCnt
`endif
);

    localparam int H_W   = $clog2(H_TOT);
    localparam int V_W   = $clog2(V_TOT);
    // A divide-by-one still needs a 1-bit register to stay legal.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOT - 1);

    // Window bounds carry one extra bit: an end bound may equal H_TOT/V_TOT,
    // which may not fit in the count width.
    localparam logic [H_W:0] H_VIS_END  = (H_W+1)'(H_VIS);
    localparam logic [H_W:0] HS_START   = (H_W+1)'(H_VIS + H_FP);
    localparam logic [H_W:0] HS_END     = (H_W+1)'(H_VIS + H_FP + H_SYNC);
    localparam logic [V_W:0] V_VIS_END  = (V_W+1)'(V_VIS);
    localparam logic [V_W:0] VS_START   = (V_W+1)'(V_VIS + V_FP);
    localparam logic [V_W:0] VS_END     = (V_W+1)'(V_VIS + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    generate
        if (H_VIS + H_FP + H_SYNC > H_TOT) begin : g_bad_h_timing
            $error("vga_timing_gen: H_VIS+H_FP+H_SYNC exceeds H_TOT");
        end
        if (V_VIS + V_FP + V_SYNC > V_TOT) begin : g_bad_v_timing
            $error("vga_timing_gen: V_VIS+V_FP+V_SYNC exceeds V_TOT");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (H_TOT < 2 || V_TOT < 2) begin : g_bad_tot
            $error("vga_timing_gen: H_TOT and V_TOT must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Internal state and next-state values
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             div_wrap;

    logic [H_W-1:0]   h_next;
    logic [V_W-1:0]   v_next;
    logic             line_next;
    logic             frame_next;
    logic             hs_next;
    logic             vs_next;
    logic             active_next;

    always_comb begin
        div_wrap    = (div == DIV_LAST);
        div_next    = div_wrap ? '0 : div + 1'b1;

        h_next      = oCountH;
        v_next      = oCountV;
        line_next   = 1'b0;
        frame_next  = 1'b0;

        if (div_wrap) begin
            if (oCountH == H_LAST) begin
                h_next    = '0;
                line_next = 1'b1;
                if (oCountV == V_LAST) begin
                    v_next     = '0;
                    frame_next = 1'b1;
                end else begin
                    v_next = oCountV + 1'b1;
                end
            end else begin
                h_next = oCountH + 1'b1;
            end
        end

        // Flags are decoded from the counts being loaded this cycle, which
        // keeps them aligned with oCountH/oCountV after the register.
        hs_next     = !(({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END));
        vs_next     = !(({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END));
        active_next = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            div         <= '0;
            oCountH     <= '0;
            oCountV     <= '0;
            oPixTick    <= 1'b0;
            oLineStart  <= 1'b0;
            oFrameStart <= 1'b0;
            oHS         <= 1'b1;
            oVS         <= 1'b1;
            oActive     <= 1'b1;
        end else begin
            div         <= div_next;
            oCountH     <= h_next;
            oCountV     <= v_next;
            oPixTick    <= div_wrap;
            oLineStart  <= line_next;
            oFrameStart <= frame_next;
            oHS         <= hs_next;
            oVS         <= vs_next;
            oActive     <= active_next;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oFrameCnt <= '0;
        end else if (frame_next) begin
            oFrameCnt <= oFrameCnt + 16'd1;
        end
    end
`endif

endmodule
